// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS main control FSM with memory-ready wait and halt/fault tracking
module multicycle_control #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             Halted,
  output logic [1:0]       Fault,
  output logic [CNT_W-1:0] InstrCount
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RCOMP  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        fault_q, next_fault;
  logic              wait_state, timed_out, retire;
  logic              pc_write, ir_write, mem_read, mem_write, reg_write;

  assign wait_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timed_out  = wait_state && !MemReady && (wait_cnt == WAIT_W'(TIMEOUT));

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      fault_q    <= 2'b00;
      InstrCount <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        wait_cnt <= '0;
      else if (wait_state && !MemReady)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire)
        InstrCount <= InstrCount + CNT_W'(1);
      if (next_state == S_HALT && state != S_HALT)
        fault_q <= next_fault;
    end
  end

  always_comb begin
    next_state = state;
    next_fault = 2'b00;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    IorD       = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSource   = 2'b00;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ALUSrcB  = 2'b01;
        ir_write = MemReady;
        pc_write = MemReady;
        if (MemReady) begin
          next_state = S_DECODE;
        end else if (timed_out) begin
          next_state = S_HALT;
          next_fault = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW:   next_state = S_MEMADR;
          OP_R:           next_state = S_EXEC;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J:           next_state = S_JUMP;
          OP_ADDI:        next_state = S_ADDIEX;
          default: begin
            next_state = S_HALT;
            next_fault = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD     = 1'b1;
        mem_read = 1'b1;
        if (MemReady) begin
          next_state = S_MEMWB;
        end else if (timed_out) begin
          next_state = S_HALT;
          next_fault = FAULT_TIMEOUT;
        end
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
        if (MemReady) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end else if (timed_out) begin
          next_state = S_HALT;
          next_fault = FAULT_TIMEOUT;
        end
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        next_state = S_RCOMP;
      end
      S_RCOMP: begin
        RegDst     = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSource   = 2'b01;
        pc_write   = (Op == OP_BNE) ? ~Zero : Zero;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        pc_write   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT: next_state = S_HALT;
      default: begin
        next_state = S_HALT;
        next_fault = FAULT_ILLEGAL;
      end
    endcase
  end

  // Strobes are gated by reset itself so a write in flight drops immediately, not at the next edge.
  assign PCWrite  = pc_write & reset;
  assign IRWrite  = ir_write & reset;
  assign MemRead  = mem_read & reset;
  assign MemWrite = mem_write & reset;
  assign RegWrite = reg_write & reset;

  assign State  = state;
  assign Halted = (state == S_HALT);
  assign Fault  = fault_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  Op = 6'b000000;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource, Fault;
  logic [3:0]  State;
  logic        Halted;
  logic [31:0] InstrCount;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  multicycle_control #(.TIMEOUT(15), .CNT_W(32)) dut (
    .CLK(CLK), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .State(State), .Halted(Halted), .Fault(Fault), .InstrCount(InstrCount)
  );

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    MemReady = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (State !== 4'd0 || InstrCount !== 32'd0 || Fault !== 2'b00 || Halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: State=%0d Count=%0d Fault=%b Halted=%b, want 0 0 00 0", State, InstrCount, Fault, Halted);
    end
    checks++;
    if ({PCWrite, IRWrite, MemRead, MemWrite, RegWrite} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 00000", {PCWrite, IRWrite, MemRead, MemWrite, RegWrite});
    end
    @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic test_addi_rtype();
    logic [5:0] ops [9] = '{6'b001000, 6'b001000, 6'b001000, 6'b001000,
                            6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    int         st  [9] = '{0, 1, 10, 11, 0, 1, 6, 7, 0};
    logic       rw  [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    MemReady = 1'b1;
    for (int i = 0; i < 9; i++) begin
      Op = ops[i];
      #1;
      checks++;
      if (State !== st[i][3:0] || RegWrite !== rw[i]) begin
        errors++;
        $display("FAIL addi_rtype[%0d]: State=%0d RegWrite=%b want %0d %b", i, State, RegWrite, st[i], rw[i]);
      end
      if (i == 6) begin
        checks++;
        if (ALUOp !== 2'b10 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin
          errors++;
          $display("FAIL exec_selects: ALUOp=%b ALUSrcA=%b ALUSrcB=%b want 10 1 00", ALUOp, ALUSrcA, ALUSrcB);
        end
      end
      if (i < 8) @(negedge CLK);
    end
    checks++;
    if (InstrCount !== 32'd2) begin
      errors++;
      $display("FAIL addi_rtype_count: got %0d want 2", InstrCount);
    end
  endtask

  task automatic test_lw_wait();
    int   st [9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    logic rd [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    Op = 6'b100011;
    for (int i = 0; i < 9; i++) begin
      MemReady = rd[i];
      #1;
      checks++;
      if (State !== st[i][3:0]) begin
        errors++;
        $display("FAIL lw_state[%0d]: got %0d want %0d", i, State, st[i]);
      end
      if (st[i] == 3) begin
        checks++;
        if (MemRead !== 1'b1 || IorD !== 1'b1) begin
          errors++;
          $display("FAIL lw_memrd[%0d]: MemRead=%b IorD=%b want 1 1", i, MemRead, IorD);
        end
      end
      if (i == 7) begin
        checks++;
        if (RegWrite !== 1'b1 || MemtoReg !== 1'b1 || RegDst !== 1'b0) begin
          errors++;
          $display("FAIL lw_memwb: RegWrite=%b MemtoReg=%b RegDst=%b want 1 1 0", RegWrite, MemtoReg, RegDst);
        end
      end
      if (i < 8) @(negedge CLK);
    end
    checks++;
    if (InstrCount !== 32'd3) begin
      errors++;
      $display("FAIL lw_count: got %0d want 3", InstrCount);
    end
  endtask

  task automatic test_branch();
    logic [5:0] bop [3] = '{6'b000100, 6'b000101, 6'b000101};
    logic       bz  [3] = '{1, 1, 0};
    logic       bpc [3] = '{1, 0, 1};
    MemReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      Op = bop[k];
      Zero = bz[k];
      @(negedge CLK);
      @(negedge CLK);
      #1;
      checks++;
      if (State !== 4'd8 || PCWrite !== bpc[k] || PCSource !== 2'b01 || ALUOp !== 2'b01) begin
        errors++;
        $display("FAIL branch[%0d]: State=%0d PCWrite=%b PCSource=%b ALUOp=%b want 8 %b 01 01",
                 k, State, PCWrite, PCSource, ALUOp, bpc[k]);
      end
      @(negedge CLK);
    end
    #1;
    checks++;
    if (State !== 4'd0 || InstrCount !== 32'd6) begin
      errors++;
      $display("FAIL branch_count: State=%0d Count=%0d want 0 6", State, InstrCount);
    end
  endtask

  task automatic test_timeout_recover();
    Op = 6'b000010;
    for (int i = 0; i < 16; i++) begin
      MemReady = (i == 15);
      #1;
      checks++;
      if (State !== 4'd0 || IRWrite !== (i == 15)) begin
        errors++;
        $display("FAIL timeout_recover[%0d]: State=%0d IRWrite=%b want 0 %b", i, State, IRWrite, (i == 15));
      end
      @(negedge CLK);
    end
    #1;
    checks++;
    if (State !== 4'd1 || Halted !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover_decode: State=%0d Halted=%b want 1 0", State, Halted);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (State !== 4'd9 || PCWrite !== 1'b1 || PCSource !== 2'b10) begin
      errors++;
      $display("FAIL jump: State=%0d PCWrite=%b PCSource=%b want 9 1 10", State, PCWrite, PCSource);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (State !== 4'd0 || InstrCount !== 32'd7) begin
      errors++;
      $display("FAIL jump_count: State=%0d Count=%0d want 0 7", State, InstrCount);
    end
  endtask

  task automatic test_async_reset_memwr();
    Op = 6'b101011;
    MemReady = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    MemReady = 1'b0;
    @(negedge CLK);
    #1;
    checks++;
    if (State !== 4'd5 || MemWrite !== 1'b1 || IorD !== 1'b1) begin
      errors++;
      $display("FAIL memwr: State=%0d MemWrite=%b IorD=%b want 5 1 1", State, MemWrite, IorD);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || State !== 4'd0 || InstrCount !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: MemWrite=%b State=%0d Count=%0d want 0 0 0", MemWrite, State, InstrCount);
    end
    @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic test_timeout_halt();
    do_reset();
    MemReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (State !== 4'd0) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: State=%0d want 0", i, State);
      end
      @(negedge CLK);
    end
    #1;
    checks++;
    if (State !== 4'd12 || Halted !== 1'b1 || Fault !== 2'b10 || MemRead !== 1'b0) begin
      errors++;
      $display("FAIL timeout_halt: State=%0d Halted=%b Fault=%b MemRead=%b want 12 1 10 0", State, Halted, Fault, MemRead);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    MemReady = 1'b1;
    Op = 6'b111111;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (State !== 4'd12 || Halted !== 1'b1 || Fault !== 2'b01) begin
      errors++;
      $display("FAIL illegal: State=%0d Halted=%b Fault=%b want 12 1 01", State, Halted, Fault);
    end
    for (int i = 0; i < 10; i++) begin
      MemReady = i[0];
      Zero = i[1];
      Op = (i < 5) ? 6'b000010 : 6'b100011;
      #1;
      checks++;
      if ({PCWrite, IRWrite, MemRead, MemWrite, RegWrite} !== 5'b00000 || State !== 4'd12 || Fault !== 2'b01) begin
        errors++;
        $display("FAIL halt_hold[%0d]: strobes=%b State=%0d Fault=%b want 00000 12 01",
                 i, {PCWrite, IRWrite, MemRead, MemWrite, RegWrite}, State, Fault);
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_addi_rtype();
    test_lw_wait();
    test_branch();
    test_timeout_recover();
    test_async_reset_memwr();
    test_timeout_halt();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath: one shared ALU, one unified instruction/data memory, and IR/A/B/ALUOut holding registers.
- Sequences fetch, decode, execute, memory and writeback over several CLK cycles.
- Waits on a memory-ready handshake and drives every datapath mux select and write strobe.
- Counts retired instructions and halts on an illegal opcode or a memory timeout.

Parameters:
- TIMEOUT, 15: maximum consecutive cycles a memory state waits for MemReady before faulting.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  6  IR[31:26], valid from DECODE onward.
- Zero  in  1  ALU zero flag, combinational from the datapath.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC load enable (branch condition already folded in).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR load enable.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2.
- ALUOp  out  2  ALU control: 00 = add, 01 = sub, 10 = funct.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- State  out  4  current state code, for debug.
- Halted  out  1  FSM is in HALT.
- Fault  out  2  halt cause: 00 none, 01 illegal opcode, 10 memory timeout.
- InstrCount  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (reset low, asynchronous): State = FETCH, wait counter = 0, InstrCount = 0, Fault = 00, Halted = 0. While reset is low, all strobes are 0 (PCWrite, IRWrite, MemRead, MemWrite, RegWrite).
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, bne = 000101, j = 000010, addi = 001000.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RCOMP 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, HALT 12.
- Outputs are Moore, except that PCWrite and IRWrite in FETCH, and PCWrite in BRANCH, are gated as described below. Selects not listed for a state are 0.
- FETCH: IorD = 0, MemRead = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00. IRWrite = PCWrite = MemReady. Go to DECODE when MemReady = 1, otherwise stay.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. Next state by Op:
  - lw, sw -> MEMADR
  - R -> EXEC
  - beq, bne -> BRANCH
  - j -> JUMP
  - addi -> ADDIEX
  - any other opcode -> HALT with Fault = 01
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: IorD = 1, MemRead = 1. Go to MEMWB on MemReady.
- MEMWB: RegDst = 0, MemtoReg = 1, RegWrite = 1. Go to FETCH.
- MEMWR: IorD = 1, MemWrite = 1 held until MemReady. Go to FETCH on MemReady.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Go to RCOMP.
- RCOMP: RegDst = 1, MemtoReg = 0, RegWrite = 1. Go to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSource = 01. PCWrite = Zero for beq, ~Zero for bne. Go to FETCH.
- JUMP: PCSource = 10, PCWrite = 1. Go to FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Go to ADDIWB.
- ADDIWB: RegDst = 0, MemtoReg = 0, RegWrite = 1. Go to FETCH.
- Retirement: InstrCount increments by 1 on every transition from MEMWB, MEMWR, RCOMP, BRANCH, JUMP or ADDIWB into FETCH. It wraps modulo 2^CNT_W.
- Timeout: in FETCH, MEMRD and MEMWR, the wait counter increments every cycle MemReady = 0 and clears on any state change.
  - When the counter reaches TIMEOUT with MemReady still 0, the next state is HALT with Fault = 10.
  - MemReady = 1 in that same cycle wins: the access completes normally.
- HALT: all strobes 0, Halted = 1, Fault held. HALT is absorbing; only reset leaves it.
- Reset mid-instruction: asynchronous return to FETCH. No register or memory write is issued after reset asserts.

Test Plan:
- addi then R-type: reset low 2 cycles then high, MemReady tied 1, IR = addi $t0,$zero,5 then add $t1,$t0,$t0 -> states 0,1,10,11,0,1,6,7,0; RegWrite high exactly in the ADDIWB and RCOMP cycles; InstrCount = 2.
- lw with memory wait: MemReady low 3 cycles in MEMRD -> FSM holds state 3 with MemRead = 1 for 4 cycles; RegWrite = 1 and MemtoReg = 1 in MEMWB; total lw latency 8 cycles.
- beq/bne: beq with Zero = 1 -> PCWrite = 1, PCSource = 01 in state 8. bne with Zero = 1 -> PCWrite = 0. Both increment InstrCount.
- Illegal opcode: Op = 111111 in DECODE -> State = 12, Halted = 1, Fault = 01 next cycle; all strobes stay 0 for 10 further cycles.
- Timeout: MemReady held 0 in FETCH -> HALT with Fault = 10 after 16 FETCH cycles. Repeat with MemReady = 1 on the 16th cycle -> normal DECODE.
- Async reset mid-MEMWR: drop reset while MemWrite = 1 -> MemWrite falls without waiting for CLK; State = 0 and InstrCount = 0 after reset.
